// File: rtl/mux_arb_pkg.sv
// Shared encodings for the packet-aware 2:1 round-robin arbiter.
package mux_arb_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_bus.sv
// WIDTH-bit 2:1 multiplexer: y = sel ? b : a.
module mux2_bus #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Pure select, no transformation of the payload.
  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Packet-aware round-robin arbiter between sources A and B feeding a
// single-entry registered output slot. Grant is held for a whole packet.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  output logic             y_sel,
  input  logic             y_ready
);

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             last_grant_nxt;
  logic             load;
  logic             grant_sel;
  logic             grant_vld;
  logic             lock;
  logic             ready_sel;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  // Data and end-of-packet steered by the same combinational grant.
  mux2_bus #(.WIDTH(WIDTH)) u_mux_data (
    .sel (grant_sel),
    .a   (a_data),
    .b   (b_data),
    .y   (sel_data)
  );

  mux2_bus #(.WIDTH(1)) u_mux_last (
    .sel (grant_sel),
    .a   (a_last),
    .b   (b_last),
    .y   (sel_last)
  );

  // Grant selection, ready decode and next-state logic.
  always_comb begin
    grant_sel      = SEL_A;
    grant_vld      = 1'b0;
    lock           = 1'b0;
    state_nxt      = state;
    last_grant_nxt = last_grant;

    load = ~y_valid | y_ready;

    case (state)
      ST_LOCK_A: begin
        grant_sel = SEL_A;
        grant_vld = a_valid;
        lock      = 1'b1;
      end
      ST_LOCK_B: begin
        grant_sel = SEL_B;
        grant_vld = b_valid;
        lock      = 1'b1;
      end
      default: begin
        if (a_valid && b_valid) begin
          grant_sel = ~last_grant;
        end else if (b_valid) begin
          grant_sel = SEL_B;
        end else begin
          grant_sel = SEL_A;
        end
        grant_vld = a_valid | b_valid;
      end
    endcase

    // A locked source sees ready whenever the slot can load; in IDLE only
    // the granted, valid source does. Reset masks both.
    ready_sel = ~rst & load & (lock | grant_vld);
    a_ready   = ready_sel & (grant_sel == SEL_A);
    b_ready   = ready_sel & (grant_sel == SEL_B);
    accept    = ready_sel & grant_vld;

    if (accept) begin
      last_grant_nxt = grant_sel;
      if (sel_last) begin
        state_nxt = ST_IDLE;
      end else if (grant_sel == SEL_B) begin
        state_nxt = ST_LOCK_B;
      end else begin
        state_nxt = ST_LOCK_A;
      end
    end
  end

  // State, arbitration history and the output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= SEL_B;
      y_valid    <= 1'b0;
      y_data     <= '0;
      y_last     <= 1'b0;
      y_sel      <= SEL_A;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      if (accept) begin
        y_valid <= 1'b1;
        y_data  <= sel_data;
        y_last  <= sel_last;
        y_sel   <= grant_sel;
      end else if (load) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter with hand-computed expectations.
module tb_mux2_rr_arbiter;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             b_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_last;
  logic             y_sel;
  logic             y_ready;

  int n_checks;
  int n_fail;

  mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_last  (a_last),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_last  (y_last),
    .y_sel   (y_sel),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational readies settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic check_y(input string tag, input logic v, input logic [7:0] d,
                         input logic l, input logic s);
    check_eq({tag, " y_valid"}, 32'(y_valid), 32'(v));
    check_eq({tag, " y_data"},  32'(y_data),  32'(d));
    check_eq({tag, " y_last"},  32'(y_last),  32'(l));
    check_eq({tag, " y_sel"},   32'(y_sel),   32'(s));
  endtask

  task automatic check_rdy(input string tag, input logic ar, input logic br);
    check_eq({tag, " a_ready"}, 32'(a_ready), 32'(ar));
    check_eq({tag, " b_ready"}, 32'(b_ready), 32'(br));
  endtask

  logic [7:0] alt_data [4];
  logic       alt_sel  [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    alt_data[0] = 8'h11; alt_data[1] = 8'h22; alt_data[2] = 8'h11; alt_data[3] = 8'h22;
    alt_sel[0]  = 1'b0;  alt_sel[1]  = 1'b1;  alt_sel[2]  = 1'b0;  alt_sel[3]  = 1'b1;

    // Reset held with both sources valid
    rst = 1'b1; y_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'h22; b_last = 1'b1;
    cyc();
    cyc();
    settle();
    check_y("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    check_rdy("reset", 1'b0, 1'b0);

    // Single-beat packets from both: A first, then strict alternation
    rst = 1'b0;
    settle();
    check_rdy("alt first", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_y($sformatf("alt%0d", i), 1'b1, alt_data[i], 1'b1, alt_sel[i]);
    end
    // last_grant is now B

    // Three-beat A packet while B stays valid
    a_data = 8'hA1; a_last = 1'b0;
    settle();
    check_rdy("pkt beat1", 1'b1, 1'b0);
    cyc();
    check_y("pkt y1", 1'b1, 8'hA1, 1'b0, 1'b0);
    a_data = 8'hA2;
    settle();
    check_rdy("pkt beat2", 1'b1, 1'b0);
    cyc();
    check_y("pkt y2", 1'b1, 8'hA2, 1'b0, 1'b0);
    a_data = 8'hA3; a_last = 1'b1;
    settle();
    check_rdy("pkt beat3", 1'b1, 1'b0);
    cyc();
    check_y("pkt y3", 1'b1, 8'hA3, 1'b1, 1'b0);
    settle();
    check_rdy("pkt after", 1'b0, 1'b1);
    cyc();
    check_y("pkt then B", 1'b1, 8'h22, 1'b1, 1'b1);

    // Backpressure for 4 cycles with the B beat held in the slot
    y_ready = 1'b0; a_data = 8'h33;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_rdy($sformatf("bp%0d", i), 1'b0, 1'b0);
      check_y($sformatf("bp%0d", i), 1'b1, 8'h22, 1'b1, 1'b1);
      cyc();
    end
    y_ready = 1'b1;
    settle();
    check_rdy("bp release", 1'b1, 1'b0);
    cyc();
    check_y("bp resume", 1'b1, 8'h33, 1'b1, 1'b0);

    // B packet with a 3-cycle bubble; A must stay blocked
    b_data = 8'hB1; b_last = 1'b0;
    settle();
    check_rdy("lockb start", 1'b0, 1'b1);
    cyc();
    check_y("lockb y1", 1'b1, 8'hB1, 1'b0, 1'b1);
    b_valid = 1'b0; a_data = 8'h44;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_rdy($sformatf("bubble%0d", i), 1'b0, 1'b1);
      check_eq($sformatf("bubble%0d y_valid", i), 32'(y_valid), (i == 0) ? 32'd1 : 32'd0);
      cyc();
    end
    b_valid = 1'b1; b_data = 8'hB2; b_last = 1'b1;
    settle();
    check_rdy("lockb last", 1'b0, 1'b1);
    cyc();
    check_y("lockb y2", 1'b1, 8'hB2, 1'b1, 1'b1);
    b_valid = 1'b0;
    settle();
    check_rdy("free to A", 1'b1, 1'b0);
    cyc();
    check_y("A after B", 1'b1, 8'h44, 1'b1, 1'b0);

    // Reset in the middle of an A packet
    a_data = 8'h55; a_last = 1'b0;
    settle();
    check_rdy("mid pkt", 1'b1, 1'b0);
    cyc();
    check_y("mid pkt y", 1'b1, 8'h55, 1'b0, 1'b0);
    rst = 1'b1; b_valid = 1'b1;
    settle();
    check_rdy("mid rst", 1'b0, 1'b0);
    cyc();
    check_y("after rst", 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0; a_last = 1'b1;
    settle();
    check_rdy("rst tie", 1'b1, 1'b0);
    cyc();
    check_y("rst tie y", 1'b1, 8'h55, 1'b1, 1'b0);
    settle();
    check_rdy("rst tie next", 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
